// File: rtl/uncache_axi_bridge.sv
// Uncached request to single-beat AXI bridge.
// One transaction in flight; refresh pulses once on completion.
module uncache_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        axi_en,
  input  logic [3:0]  axi_wsel,
  input  logic [31:0] axi_addr,
  input  logic [31:0] axi_wdata,
  output logic        refresh,
  output logic [31:0] axi_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_D,
    WR_AW,
    WR_B,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic        refresh_nxt;
  logic [31:0] axi_rdata_nxt;
  logic [3:0]  arid_nxt;
  logic [31:0] araddr_nxt;
  logic [3:0]  arlen_nxt;
  logic [2:0]  arsize_nxt;
  logic [1:0]  arburst_nxt;
  logic        arvalid_nxt;
  logic        rready_nxt;
  logic [3:0]  awid_nxt;
  logic [31:0] awaddr_nxt;
  logic [3:0]  awlen_nxt;
  logic [2:0]  awsize_nxt;
  logic [1:0]  awburst_nxt;
  logic        awvalid_nxt;
  logic [3:0]  wid_nxt;
  logic [31:0] wdata_nxt;
  logic [3:0]  wstrb_nxt;
  logic        wlast_nxt;
  logic        wvalid_nxt;
  logic        bready_nxt;

  // A write channel counts as finished once its valid has
  // dropped or its handshake happens on the coming edge.
  logic aw_ok;
  logic w_ok;
  logic is_rd;

  assign aw_ok = !awvalid || awready;
  assign w_ok  = !wvalid || wready;
  assign is_rd = (axi_wsel == 4'b0000);

  // Response ids and status are not used by the CPU side.
  logic unused_rsp;
  assign unused_rsp = ^{rid, rresp, rlast, bid, bresp};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (axi_en) begin
          state_nxt = is_rd ? RD_A : WR_AW;
        end
      end
      RD_A: begin
        if (arready) begin
          state_nxt = RD_D;
        end
      end
      RD_D: begin
        if (rvalid) begin
          state_nxt = DONE;
        end
      end
      WR_AW: begin
        if (aw_ok && w_ok) begin
          state_nxt = WR_B;
        end
      end
      WR_B: begin
        if (bvalid) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Next value of every registered output.
  always_comb begin
    refresh_nxt   = 1'b0;
    axi_rdata_nxt = axi_rdata;
    arid_nxt      = arid;
    araddr_nxt    = araddr;
    arlen_nxt     = arlen;
    arsize_nxt    = arsize;
    arburst_nxt   = arburst;
    arvalid_nxt   = arvalid;
    rready_nxt    = rready;
    awid_nxt      = awid;
    awaddr_nxt    = awaddr;
    awlen_nxt     = awlen;
    awsize_nxt    = awsize;
    awburst_nxt   = awburst;
    awvalid_nxt   = awvalid;
    wid_nxt       = wid;
    wdata_nxt     = wdata;
    wstrb_nxt     = wstrb;
    wlast_nxt     = wlast;
    wvalid_nxt    = wvalid;
    bready_nxt    = bready;
    unique case (state)
      IDLE: begin
        if (axi_en && is_rd) begin
          arvalid_nxt = 1'b1;
          araddr_nxt  = axi_addr;
          arid_nxt    = AXI_ID;
          arlen_nxt   = 4'd0;
          arsize_nxt  = 3'b010;
          arburst_nxt = 2'b01;
        end else if (axi_en) begin
          awvalid_nxt = 1'b1;
          awaddr_nxt  = {axi_addr[31:2], 2'b00};
          awid_nxt    = AXI_ID;
          awlen_nxt   = 4'd0;
          awsize_nxt  = 3'b010;
          awburst_nxt = 2'b01;
          wvalid_nxt  = 1'b1;
          wid_nxt     = AXI_ID;
          wdata_nxt   = axi_wdata;
          wstrb_nxt   = axi_wsel;
          wlast_nxt   = 1'b1;
        end
      end
      RD_A: begin
        if (arready) begin
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
        end
      end
      RD_D: begin
        if (rvalid) begin
          rready_nxt    = 1'b0;
          axi_rdata_nxt = rdata;
          refresh_nxt   = 1'b1;
        end
      end
      WR_AW: begin
        if (awready) begin
          awvalid_nxt = 1'b0;
        end
        if (wready) begin
          wvalid_nxt = 1'b0;
        end
        if (aw_ok && w_ok) begin
          bready_nxt = 1'b1;
        end
      end
      WR_B: begin
        if (bvalid) begin
          bready_nxt  = 1'b0;
          refresh_nxt = 1'b1;
        end
      end
      DONE: begin
        refresh_nxt = 1'b0;
      end
      default: begin
        refresh_nxt = 1'b0;
      end
    endcase
  end

  // Output registers; reset abandons any bus transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh   <= 1'b0;
      axi_rdata <= '0;
      arid      <= '0;
      araddr    <= '0;
      arlen     <= '0;
      arsize    <= '0;
      arburst   <= '0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      awid      <= '0;
      awaddr    <= '0;
      awlen     <= '0;
      awsize    <= '0;
      awburst   <= '0;
      awvalid   <= 1'b0;
      wid       <= '0;
      wdata     <= '0;
      wstrb     <= '0;
      wlast     <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
    end else begin
      refresh   <= refresh_nxt;
      axi_rdata <= axi_rdata_nxt;
      arid      <= arid_nxt;
      araddr    <= araddr_nxt;
      arlen     <= arlen_nxt;
      arsize    <= arsize_nxt;
      arburst   <= arburst_nxt;
      arvalid   <= arvalid_nxt;
      rready    <= rready_nxt;
      awid      <= awid_nxt;
      awaddr    <= awaddr_nxt;
      awlen     <= awlen_nxt;
      awsize    <= awsize_nxt;
      awburst   <= awburst_nxt;
      awvalid   <= awvalid_nxt;
      wid       <= wid_nxt;
      wdata     <= wdata_nxt;
      wstrb     <= wstrb_nxt;
      wlast     <= wlast_nxt;
      wvalid    <= wvalid_nxt;
      bready    <= bready_nxt;
    end
  end

endmodule

// File: tb/tb_uncache_axi_bridge.sv
// Bench for uncache_axi_bridge: directed and random
// transactions against a cycle-counting slave model.
module tb_uncache_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        axi_en;
  logic [3:0]  axi_wsel;
  logic [31:0] axi_addr;
  logic [31:0] axi_wdata;
  logic        refresh;
  logic [31:0] axi_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  always #5 clk = ~clk;

  uncache_axi_bridge dut (
    .clk(clk), .rst(rst),
    .axi_en(axi_en), .axi_wsel(axi_wsel),
    .axi_addr(axi_addr), .axi_wdata(axi_wdata),
    .refresh(refresh), .axi_rdata(axi_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb),
    .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid),
    .bready(bready)
  );

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] exp_rdata = '0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, got, want);
  endtask

  task automatic idle_slave();
    arready = 1'b0;
    rvalid  = 1'b0;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
  endtask

  // One upstream request against a slave that waits the given
  // number of cycles after each valid before answering.
  task automatic run_txn(input logic [3:0] ws,
                         input logic [31:0] ad,
                         input logic [31:0] wd,
                         input logic [31:0] rd,
                         input int ard, input int rdd,
                         input int awd, input int wdd,
                         input int bd);
    int cyc, post, lat;
    int ar_hs, ar_wait, r_hs, r_wait, r_cyc;
    int aw_hs, aw_wait, w_hs, w_wait;
    int b_hs, b_wait, b_cyc;
    int ref_n, ref_cyc, bad_ar, bad_aw, bad_w, early_b;
    bit r_on, r_done, aw_done, w_done, b_done, seen;
    bit ar_hit, r_hit, aw_hit, w_hit, b_hit, is_rd;
    logic [31:0] rd_at_ref;
    cyc = 0; post = 0; lat = 0;
    ar_hs = 0; ar_wait = 0; r_hs = 0; r_wait = 0;
    r_cyc = -9; aw_hs = 0; aw_wait = 0;
    w_hs = 0; w_wait = 0; b_hs = 0; b_wait = 0;
    b_cyc = -9; ref_n = 0; ref_cyc = -1;
    bad_ar = 0; bad_aw = 0; bad_w = 0; early_b = 0;
    r_on = 0; r_done = 0; aw_done = 0;
    w_done = 0; b_done = 0; seen = 0;
    is_rd = (ws == 4'b0000);
    rd_at_ref = 'x;
    axi_en = 1'b1;
    axi_wsel = ws;
    axi_addr = ad;
    axi_wdata = wd;
    rdata = rd;
    idle_slave();
    while (cyc < 200 && post < 3) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      ar_hit = 0; r_hit = 0; aw_hit = 0;
      w_hit = 0; b_hit = 0;
      arready = 1'b0;
      if (arvalid) begin
        if (araddr !== ad || arsize !== 3'd2 ||
            arlen !== 4'd0 || arburst !== 2'b01 ||
            arid !== 4'd1) bad_ar++;
        if (ar_wait >= ard) begin
          arready = 1'b1;
          ar_hs++;
          ar_hit = 1;
        end else ar_wait++;
      end
      rvalid = 1'b0;
      if (r_on && !r_done) begin
        if (r_wait >= rdd) begin
          rvalid = 1'b1;
          if (rready) begin
            r_hs++;
            r_cyc = cyc;
            r_hit = 1;
          end
        end else r_wait++;
      end
      awready = 1'b0;
      if (awvalid) begin
        if (awaddr !== {ad[31:2], 2'b00} ||
            awsize !== 3'd2 || awlen !== 4'd0 ||
            awburst !== 2'b01 || awid !== 4'd1) bad_aw++;
        if (aw_wait >= awd) begin
          awready = 1'b1;
          aw_hs++;
          aw_hit = 1;
        end else aw_wait++;
      end
      wready = 1'b0;
      if (wvalid) begin
        if (wdata !== wd || wstrb !== ws ||
            wlast !== 1'b1 || wid !== 4'd1) bad_w++;
        if (w_wait >= wdd) begin
          wready = 1'b1;
          w_hs++;
          w_hit = 1;
        end else w_wait++;
      end
      if (bready && !(aw_done && w_done)) early_b++;
      bvalid = 1'b0;
      if (aw_done && w_done && !b_done) begin
        if (b_wait >= bd) begin
          bvalid = 1'b1;
          if (bready) begin
            b_hs++;
            b_cyc = cyc;
            b_hit = 1;
          end
        end else b_wait++;
      end
      if (refresh) begin
        ref_n++;
        if (!seen) begin
          seen = 1;
          ref_cyc = cyc;
          rd_at_ref = axi_rdata;
        end
      end
      if (seen) begin
        axi_en = 1'b0;
        post++;
      end
      if (ar_hit) r_on = 1;
      if (r_hit) r_done = 1;
      if (aw_hit) aw_done = 1;
      if (w_hit) w_done = 1;
      if (b_hit) b_done = 1;
    end
    axi_en = 1'b0;
    idle_slave();
    rdata = ~rd;
    chk("refresh_seen", 32'(seen), 32'd1);
    chk("refresh_count", ref_n, 32'd1);
    if (is_rd) begin
      exp_rdata = rd;
      lat = 3 + ard + rdd;
      chk("ar_handshakes", ar_hs, 32'd1);
      chk("r_handshakes", r_hs, 32'd1);
      chk("aw_on_read", aw_hs + w_hs, 32'd0);
      chk("ar_payload", bad_ar, 32'd0);
      chk("refresh_after_r", ref_cyc - r_cyc, 32'd1);
    end else begin
      lat = 3 + (awd > wdd ? awd : wdd) + bd;
      chk("aw_handshakes", aw_hs, 32'd1);
      chk("w_handshakes", w_hs, 32'd1);
      chk("b_handshakes", b_hs, 32'd1);
      chk("ar_on_write", ar_hs, 32'd0);
      chk("aw_payload", bad_aw, 32'd0);
      chk("w_payload", bad_w, 32'd0);
      chk("bready_early", early_b, 32'd0);
      chk("refresh_after_b", ref_cyc - b_cyc, 32'd1);
    end
    chk("latency", ref_cyc, lat);
    chk("rdata_at_refresh", rd_at_ref, exp_rdata);
    chk("rdata_hold", axi_rdata, exp_rdata);
  endtask

  task automatic reset_in_wr_b();
    int n;
    n = 0;
    axi_en = 1'b1;
    axi_wsel = 4'b0011;
    axi_addr = 32'h1000_0004;
    axi_wdata = 32'hCAFE_F00D;
    idle_slave();
    awready = 1'b1;
    wready = 1'b1;
    while (n < 20 && !bready) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("bready_before_rst", 32'(bready), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_bready", 32'(bready), 32'd0);
    chk("rst_refresh", 32'(refresh), 32'd0);
    chk("rst_valids",
        32'({arvalid, awvalid, wvalid}), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    axi_en = 1'b0;
    idle_slave();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_rdata = '0;
    chk("rst_rdata", axi_rdata, exp_rdata);
  endtask

  initial begin
    logic [3:0] ws;
    rst = 1'b1;
    axi_en = 1'b0;
    axi_wsel = '0;
    axi_addr = '0;
    axi_wdata = '0;
    rid = 4'd1;
    rdata = '0;
    rresp = '0;
    rlast = 1'b1;
    bid = 4'd1;
    bresp = '0;
    idle_slave();
    #1;
    chk("reset_valids",
        32'({arvalid, awvalid, wvalid, rready, bready}),
        32'd0);
    chk("reset_refresh", 32'(refresh), 32'd0);
    chk("reset_rdata", axi_rdata, 32'd0);
    chk("reset_araddr", araddr, 32'd0);
    chk("reset_awaddr", awaddr, 32'd0);
    chk("reset_wstrb", 32'(wstrb), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_txn(4'b0000, 32'hBFAF_F000, 32'h0,
            32'h1234_5678, 0, 0, 0, 0, 0);
    run_txn(4'b0100, 32'hBFD0_03FA, 32'h00AB_0000,
            32'h0, 0, 0, 0, 0, 0);
    run_txn(4'b1111, 32'h0000_1008, 32'h5555_AAAA,
            32'h0, 0, 0, 3, 0, 1);
    run_txn(4'b0011, 32'h0000_2002, 32'h1111_2222,
            32'h0, 0, 0, 2, 2, 0);
    run_txn(4'b0000, 32'h8000_0010, 32'h0,
            32'hDEAD_BEEF, 5, 4, 0, 0, 0);
    reset_in_wr_b();
    @(negedge clk);
    run_txn(4'b0000, 32'h0000_3000, 32'h0,
            32'h0BAD_F00D, 1, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1, 0) == 0) ws = 4'b0000;
      else ws = 4'($urandom_range(15, 1));
      run_txn(ws, $urandom, $urandom, $urandom,
              $urandom_range(4, 0), $urandom_range(4, 0),
              $urandom_range(4, 0), $urandom_range(4, 0),
              $urandom_range(4, 0));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uncache_axi_bridge.md
Name: uncache_axi_bridge

Overview:
- Downstream of the uncached-access tag stage.
- Consumes its registered request (axi_en / axi_wsel / axi_addr) plus the store data, and performs exactly one single-beat AXI transaction.
- Returns a one-cycle `refresh` completion pulse and the captured read data.
- Sits between the uncached request path and the CPU's AXI master port; one transaction outstanding at a time.

Parameters:
- AXI_ID, 4'd1, value driven on arid/awid/wid.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- axi_en  in  1  request valid; held high by upstream until `refresh` is sampled
- axi_wsel  in  4  byte write enables; 4'b0000 = read
- axi_addr  in  32  physical address
- axi_wdata  in  32  store data
- refresh  out  1  one-cycle completion pulse
- axi_rdata  out  32  read data, valid from the `refresh` cycle until the next read completes
- arid/araddr/arlen/arsize/arburst  out  4/32/4/3/2  AR channel payload
- arvalid  out  1; arready  in  1
- rid/rdata/rresp/rlast  in  4/32/2/1; rvalid  in  1; rready  out  1
- awid/awaddr/awlen/awsize/awburst  out  4/32/4/3/2  AW channel payload
- awvalid  out  1; awready  in  1
- wid/wdata/wstrb/wlast  out  4/32/4/1; wvalid  out  1; wready  in  1
- bid/bresp  in  4/2; bvalid  in  1; bready  out  1

Behaviour:
- Reset: asynchronous, active-high. All outputs are registered and clear to 0 on reset: valids, readys, refresh, axi_rdata, all payloads. State returns to IDLE, aborting any transaction in flight.
- Constant payload fields (driven whenever a valid is high):
  - arlen = awlen = 0, arburst = awburst = 2'b01, arsize = awsize = 3'b010, wlast = 1.
  - arid = awid = wid = AXI_ID.
- States: IDLE, RD_A, RD_D, WR_AW, WR_B, DONE.
- IDLE:
  - If axi_en = 1, latch addr/wsel/wdata.
  - If wsel == 0: go to RD_A with arvalid = 1 and araddr = axi_addr.
  - Otherwise: go to WR_AW with awvalid = 1 and wvalid = 1, awaddr = {axi_addr[31:2], 2'b00}, wdata = axi_wdata, wstrb = axi_wsel.
- RD_A:
  - Hold arvalid and araddr stable until arready. On the handshake edge, drop arvalid, raise rready, go to RD_D.
- RD_D:
  - On rvalid & rready: capture rdata into axi_rdata, drop rready, go to DONE.
  - rresp, rid and rlast are ignored.
- WR_AW:
  - awvalid and wvalid are retired independently, each dropping on the edge where its own ready is sampled high.
  - Handshakes may occur in either order or in the same cycle.
  - When both are complete (including same-cycle completion), raise bready and go to WR_B.
  - Payloads stay stable while their valid is high.
- WR_B:
  - On bvalid & bready: drop bready, go to DONE. bresp is ignored.
- DONE:
  - refresh = 1 for exactly this one cycle, then IDLE.
  - Upstream clears axi_en on the same edge, so no re-trigger occurs. IDLE must still require axi_en = 1 before starting.
- axi_rdata keeps its value across writes; it changes only when a read completes.
- Minimum latency, with all readys/valids already high: read = 4 cycles from axi_en sampled to the refresh cycle (IDLE→RD_A→RD_D→DONE). Write = 4 cycles (IDLE→WR_AW→WR_B→DONE).
- Never more than one outstanding transaction. A new axi_en is ignored outside IDLE.
- Reset mid-transaction: valids and readys drop immediately. Protocol abandonment is accepted under system reset.

Test Plan:
- Read, zero-wait slave: axi_en = 1, wsel = 0, addr = 0xBFAF_F000, slave returns 0x1234_5678. Required: arvalid with araddr = 0xBFAF_F000, arsize = 2; one-cycle refresh; axi_rdata = 0x1234_5678 held afterwards.
- Byte write: wsel = 4'b0100, addr = 0xBFD0_03FA, wdata = 0x00AB_0000. Required: awaddr = 0xBFD0_03F8, wstrb = 4'b0100, wlast = 1; refresh exactly 1 cycle after the bvalid handshake.
- Write with split handshakes: wready 3 cycles before awready, then awready/wready in the same cycle on a second write. Required: each valid drops only after its own handshake; bready rises only after both; one refresh per write.
- Back-pressure: arready delayed 5 cycles, rvalid delayed 4 cycles. Required: araddr and arvalid stable while waiting; exactly one refresh; no second AR issued while axi_en stays high until refresh.
- Reset asserted asynchronously mid-edge while in WR_B. Required: bready, refresh and all valids 0 immediately; next axi_en read completes normally.
